pedestal_filter_seq: RTL

Control sequencer for one channel's pedestal-recovery low-pass filter in the self-trigger path. It resets the filter and holds it in a settle phase until the baseline is trustworthy. It then tracks, and freezes the filter (enable low) while a self-trigger is active plus a hold-off, so pulses do not pull the pedestal estimate. It drives the filter's reset/enable pins and publishes a baseline-valid flag to the trigger logic.

---
 rtl/pedestal_filter_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pedestal_filter_seq.sv
// pedestal_filter_seq
//
// Control sequencer for one channel's pedestal-recovery low-pass filter.
// The sequencer first resets the filter. It then lets the filter settle until
// the baseline can be trusted. After that it tracks the baseline, and it freezes
// the filter while a self-trigger is active and for a hold-off after it.
//
// Optional feature: define PEDESTAL_FREEZE_TIMEOUT_EN to bound the time spent in
// FREEZE. Once FREEZE_MAX consecutive FREEZE cycles have passed, the block
// re-initialises the filter and pulses timeout_p. Without the macro, FREEZE is
// unbounded and timeout_p is tied low.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-high reset
//   run            in   1 = acquire/track, 0 = park the filter in reset
//   trig_in        in   self-trigger active (level)
//   filt_reset     out  filter reset pin
//   filt_enable    out  filter enable pin
//   baseline_valid out  filter output usable as pedestal
//   state_o        out  current state code (IDLE=0 INIT=1 SETTLE=2 TRACK=3 FREEZE=4)
//   timeout_p      out  one-cycle pulse on freeze timeout
//
// All outputs are registered. Each one is decoded from the next state, so it
// changes on the same edge as state_o.

module pedestal_filter_seq #(
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter int unsigned HOLDOFF       = 256,
    parameter int unsigned FREEZE_MAX    = 65535,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       trig_in,
    output logic       filt_reset,
    output logic       filt_enable,
    output logic       baseline_valid,
    output logic [2:0] state_o,
    output logic       timeout_p
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StInit   = 3'd1;
    localparam logic [2:0] StSettle = 3'd2;
    localparam logic [2:0] StTrack  = 3'd3;
    localparam logic [2:0] StFreeze = 3'd4;

    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldoffVal = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    // Out-of-range parameters are rejected at elaboration, not handled at runtime.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES >= (64'd1 << CNT_W)) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range");
    end
    if (HOLDOFF < 1 || HOLDOFF >= (64'd1 << CNT_W)) begin : g_bad_holdoff
        $error("HOLDOFF out of range");
    end
    if (FREEZE_MAX < 1 || FREEZE_MAX >= (64'd1 << CNT_W)) begin : g_bad_freeze_max
        $error("FREEZE_MAX out of range");
    end

    logic [2:0]       state_q, state_d;
    // Shared phase counter: INIT cycles, SETTLE cycles, or hold-off remaining.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;
    logic             freeze_expired;

`ifdef PEDESTAL_FREEZE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] FreezeMax = CNT_W'(FREEZE_MAX);

    // Counts consecutive FREEZE cycles. It holds 1 during the first FREEZE cycle.
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    assign freeze_expired = (state_q == StFreeze) && (freeze_cnt_q == FreezeMax);

    always_comb begin
        freeze_cnt_d = '0;
        if (state_d == StFreeze) begin
            if (state_q != StFreeze) begin
                freeze_cnt_d = CntOne;
            end else if (freeze_cnt_q != '1) begin
                freeze_cnt_d = freeze_cnt_q + CntOne;
            end else begin
                freeze_cnt_d = freeze_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freeze_cnt_q <= '0;
        end else begin
            freeze_cnt_q <= freeze_cnt_d;
        end
    end
`else
    assign freeze_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        if (!run) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (freeze_expired) begin
            // A timeout takes priority over a hold-off expiring on the same cycle.
            state_d   = StInit;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
                StInit: begin
                    // INIT is held for exactly two cycles.
                    if (cnt_q == CntOne) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        state_d = StTrack;
                        cnt_d   = '0;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StTrack: begin
                    if (trig_in) begin
                        state_d = StFreeze;
                        cnt_d   = HoldoffVal;
                    end
                end
                StFreeze: begin
                    if (trig_in) begin
                        cnt_d = HoldoffVal;
                    end else if (cnt_q == CntOne) begin
                        state_d = StTrack;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            filt_reset     <= 1'b1;
            filt_enable    <= 1'b0;
            baseline_valid <= 1'b0;
            timeout_p      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            filt_reset     <= (state_d == StIdle) || (state_d == StInit);
            filt_enable    <= (state_d == StSettle) || (state_d == StTrack);
            baseline_valid <= (state_d == StTrack) || (state_d == StFreeze);
            timeout_p      <= timeout_d;
        end
    end

    assign state_o = state_q;

endmodule
